// File: rtl/ram_wait_ctrl.sv
// rtl/ram_wait_ctrl.sv - byte-addressed data RAM with MFA/MFC handshake and programmable wait states
//
// Purpose:
//   Big-endian byte-addressed data memory for the MAR/MDR data path. A request
//   raised on MFA is latched in IDLE, held for WAIT_STATES idle cycles, then
//   performed in a single ACCESS cycle. MFC stays high in DONE until MFA drops.
//
// Parameters:
//   ADDR_W       byte-address width, depth = 2**ADDR_W bytes (must be >= 3)
//   WAIT_STATES  idle cycles between request capture and access (0..15)
//
// Ports:
//   CLK        in   rising-edge clock
//   CLR        in   synchronous active-high reset
//   MFA        in   request, held high until MFC is seen
//   RW_RAM     in   1 = read, 0 = write
//   ADDR       in   byte address
//   DATA_IN    in   write data, right-justified for byte/halfword
//   DATA_SIZE  in   00 byte, 01 halfword, 10/11 word
//   DATA_OUT   out  read data, zero-extended, right-justified
//   MFC        out  memory function complete
//   ERR        out  misaligned-access flag
//
// Configuration:
//   RAM_ALIGN_CHECK_EN  when defined, misaligned halfword/word accesses raise
//                       ERR with MFC, suppress the write and return zero.
//                       When undefined, ERR stays 0 and the low address bits
//                       are masked off for halfword/word accesses.

module ram_wait_ctrl #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              MFA,
   input  logic              RW_RAM,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [31:0]       DATA_IN,
   input  logic [1:0]        DATA_SIZE,
   output logic [31:0]       DATA_OUT,
   output logic              MFC,
   output logic              ERR
);

   localparam int                 DEPTH = 1 << ADDR_W;
   localparam logic [3:0]         WS    = 4'(WAIT_STATES);
   localparam logic [ADDR_W-1:0]  OFS1  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0]  OFS2  = ADDR_W'(2);
   localparam logic [ADDR_W-1:0]  OFS3  = ADDR_W'(3);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t state, state_n;

   logic [7:0]        mem [0:DEPTH-1];

   logic [3:0]        cnt, cnt_n;
   logic              mfc_n, err_n;
   logic [31:0]       dout_n;
   logic              cap;
   logic              we;

   // request captured in IDLE; later cycles only look at these copies
   logic              lat_rw;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_din;
   logic [1:0]        lat_size;

   logic [ADDR_W-1:0] a0, a1, a2, a3;
   logic [31:0]       rd_data;
   logic              misaligned;

   // Halfword/word accesses are forced onto their natural boundary. With the
   // alignment check enabled a misaligned request never touches memory, so the
   // masked base is harmless there too.
   always_comb begin
      a0 = lat_addr;
      case (lat_size)
         2'b00:   a0 = lat_addr;
         2'b01:   a0 = {lat_addr[ADDR_W-1:1], 1'b0};
         default: a0 = {lat_addr[ADDR_W-1:2], 2'b00};
      endcase
   end

   // byte offsets wrap modulo the memory depth through the ADDR_W-bit adders
   assign a1 = a0 + OFS1;
   assign a2 = a0 + OFS2;
   assign a3 = a0 + OFS3;

   always_comb begin
      rd_data = 32'd0;
      case (lat_size)
         2'b00:   rd_data = {24'd0, mem[a0]};
         2'b01:   rd_data = {16'd0, mem[a0], mem[a1]};
         default: rd_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
      endcase
   end

`ifdef RAM_ALIGN_CHECK_EN
   always_comb begin
      misaligned = 1'b0;
      case (lat_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = lat_addr[0];
         default: misaligned = (lat_addr[1:0] != 2'b00);
      endcase
   end
`else
   assign misaligned = 1'b0;
`endif

   // next-state and registered-output logic
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      mfc_n   = MFC;
      err_n   = ERR;
      dout_n  = DATA_OUT;
      cap     = 1'b0;
      we      = 1'b0;

      case (state)
         S_IDLE: begin
            if (MFA) begin
               cap     = 1'b1;
               cnt_n   = WS;
               state_n = (WS == 4'd0) ? S_ACCESS : S_WAIT;
            end
         end

         S_WAIT: begin
            cnt_n = cnt - 4'd1;
            if (cnt <= 4'd1) begin
               state_n = S_ACCESS;
            end
         end

         S_ACCESS: begin
            mfc_n   = 1'b1;
            state_n = S_DONE;
            if (misaligned) begin
               err_n  = 1'b1;
               dout_n = 32'd0;
            end else if (lat_rw) begin
               dout_n = rd_data;
            end else begin
               // reset on the access edge wins over the write
               we = !CLR;
            end
         end

         S_DONE: begin
            // a request whose MFA already dropped still gets a one-cycle MFC
            if (!MFA) begin
               mfc_n   = 1'b0;
               err_n   = 1'b0;
               state_n = S_IDLE;
            end
         end

         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         MFC      <= 1'b0;
         ERR      <= 1'b0;
         DATA_OUT <= 32'd0;
         lat_rw   <= 1'b0;
         lat_addr <= '0;
         lat_din  <= 32'd0;
         lat_size <= 2'b00;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         MFC      <= mfc_n;
         ERR      <= err_n;
         DATA_OUT <= dout_n;
         if (cap) begin
            lat_rw   <= RW_RAM;
            lat_addr <= ADDR;
            lat_din  <= DATA_IN;
            lat_size <= DATA_SIZE;
         end
      end
   end

   // array contents survive reset, so the storage has no reset branch
   always_ff @(posedge CLK) begin
      if (we) begin
         case (lat_size)
            2'b00: begin
               mem[a0] <= lat_din[7:0];
            end
            2'b01: begin
               mem[a0] <= lat_din[15:8];
               mem[a1] <= lat_din[7:0];
            end
            default: begin
               mem[a0] <= lat_din[31:24];
               mem[a1] <= lat_din[23:16];
               mem[a2] <= lat_din[15:8];
               mem[a3] <= lat_din[7:0];
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_wait_ctrl.sv
// tb/tb_ram_wait_ctrl.sv - self-checking bench for ram_wait_ctrl

module tb_ram_wait_ctrl;

   localparam int AW = 8;
   localparam int WS = 2;

   logic          CLK = 1'b0;
   logic          CLR;
   logic          MFA;
   logic          RW_RAM;
   logic [AW-1:0] ADDR;
   logic [31:0]   DATA_IN;
   logic [1:0]    DATA_SIZE;
   logic [31:0]   DATA_OUT;
   logic          MFC;
   logic          ERR;

   int errs   = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   ram_wait_ctrl #(.ADDR_W(AW), .WAIT_STATES(WS)) dut (
      .CLK(CLK), .CLR(CLR), .MFA(MFA), .RW_RAM(RW_RAM), .ADDR(ADDR),
      .DATA_IN(DATA_IN), .DATA_SIZE(DATA_SIZE), .DATA_OUT(DATA_OUT),
      .MFC(MFC), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errs++;
      $display("FAIL %s: no response within cycle budget at %0t", nm, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Memory is a plain byte array; a request becomes due 1+WS edges after
   // the edge that sees it, and MFC is held until MFA is seen low.
   logic [7:0]  mm [0:255];
   int          cyc    = 0;
   bit          pend   = 1'b0;
   bit          hold   = 1'b0;
   int          due    = 0;
   logic        m_rw;
   logic [7:0]  m_addr;
   logic [31:0] m_din;
   logic [1:0]  m_size;
   logic        exp_mfc  = 1'b0;
   logic        exp_err  = 1'b0;
   logic [31:0] exp_dout = 32'd0;

   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
   endfunction

   function automatic int base_of(input logic [7:0] a, input logic [1:0] s);
      return (int'(a) / nbytes(s)) * nbytes(s);
   endfunction

   function automatic bit is_mis(input logic [7:0] a, input logic [1:0] s);
`ifdef RAM_ALIGN_CHECK_EN
      return (int'(a) % nbytes(s)) != 0;
`else
      return (a == 8'd0 && s == 2'b11);
`endif
   endfunction

   always @(posedge CLK) begin
      cyc++;
      if (CLR) begin
         pend = 1'b0; hold = 1'b0;
         exp_mfc = 1'b0; exp_err = 1'b0; exp_dout = 32'd0;
      end else if (hold) begin
         if (!MFA) begin
            hold = 1'b0; exp_mfc = 1'b0; exp_err = 1'b0;
         end
      end else if (pend) begin
         if (cyc == due) begin
            int n, b;
            pend = 1'b0; hold = 1'b1; exp_mfc = 1'b1;
            n = nbytes(m_size);
            b = base_of(m_addr, m_size);
`ifdef RAM_ALIGN_CHECK_EN
            if (is_mis(m_addr, m_size)) begin
               exp_err = 1'b1; exp_dout = 32'd0;
            end else
`endif
            if (m_rw) begin
               logic [31:0] v;
               v = 32'd0;
               for (int i = 0; i < n; i++) v = (v << 8) | 32'(mm[(b + i) % 256]);
               exp_dout = v;
            end else begin
               for (int i = 0; i < n; i++) mm[(b + i) % 256] = 8'(m_din >> (8 * (n - 1 - i)));
            end
         end
      end else if (MFA) begin
         pend = 1'b1; due = cyc + 1 + WS;
         m_rw = RW_RAM; m_addr = ADDR; m_din = DATA_IN; m_size = DATA_SIZE;
      end
   end

   // compare process: outputs only change on posedge, sample on negedge
   always @(negedge CLK) begin
      if (chk_en) begin
         chk("mfc", {31'd0, MFC}, {31'd0, exp_mfc});
         chk("err", {31'd0, ERR}, {31'd0, exp_err});
         chk("data_out", DATA_OUT, exp_dout);
      end
   end

   // ---------------- stimulus ----------------
   task automatic req(input logic rw, input logic [7:0] a, input logic [31:0] d,
                      input logic [1:0] s, output logic [31:0] rd, output logic er,
                      output int lat);
      int n;
      @(negedge CLK);
      MFA = 1'b1; RW_RAM = rw; ADDR = a; DATA_IN = d; DATA_SIZE = s;
      n = 0;
      do begin @(negedge CLK); n++; end while (!MFC && n < 40);
      if (!MFC) timeout("mfc_rise");
      lat = n - 1;
      rd  = DATA_OUT;
      er  = ERR;
      MFA = 1'b0;
      ADDR = 8'(~a); DATA_IN = ~d;
      n = 0;
      do begin @(negedge CLK); n++; end while (MFC && n < 10);
      if (MFC) timeout("mfc_fall");
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;
   int          pulses;

   initial begin
      for (int i = 0; i < 256; i++) mm[i] = 8'd0;
      CLR = 1'b1; MFA = 1'b0; RW_RAM = 1'b0; ADDR = '0; DATA_IN = '0; DATA_SIZE = 2'b00;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk_en = 1'b1;
      chk("rst_mfc", {31'd0, MFC}, 32'd0);
      chk("rst_dout", DATA_OUT, 32'd0);
      chk("rst_err", {31'd0, ERR}, 32'd0);
      CLR = 1'b0;
      repeat (5) @(negedge CLK);
      chk("idle_mfc", {31'd0, MFC}, 32'd0);

      // word write / read with latency
      req(1'b0, 8'h10, 32'hDEADBEEF, 2'b10, rd, er, lat);
      chk("wr_latency", 32'(lat), 32'd3);
      req(1'b1, 8'h10, 32'h0, 2'b10, rd, er, lat);
      chk("rd_word", rd, 32'hDEADBEEF);
      chk("rd_latency", 32'(lat), 32'd3);

      // sizes and endianness
      req(1'b1, 8'h11, 32'h0, 2'b00, rd, er, lat);
      chk("rd_byte_11", rd, 32'h000000AD);
      req(1'b1, 8'h12, 32'h0, 2'b01, rd, er, lat);
      chk("rd_half_12", rd, 32'h0000BEEF);
      req(1'b0, 8'h13, 32'hFFFFFF55, 2'b00, rd, er, lat);
      req(1'b1, 8'h10, 32'h0, 2'b10, rd, er, lat);
      chk("rd_word_after_byte", rd, 32'hDEADBE55);
      req(1'b1, 8'h10, 32'h0, 2'b11, rd, er, lat);
      chk("rd_size11", rd, 32'hDEADBE55);
      req(1'b0, 8'h30, 32'h1234ABCD, 2'b01, rd, er, lat);
      req(1'b1, 8'h30, 32'h0, 2'b01, rd, er, lat);
      chk("rd_half_30", rd, 32'h0000ABCD);

      // top-of-memory word and neighbour byte
      req(1'b0, 8'h00, 32'h000000A5, 2'b00, rd, er, lat);
      req(1'b0, 8'hFC, 32'h11223344, 2'b10, rd, er, lat);
      req(1'b1, 8'hFF, 32'h0, 2'b00, rd, er, lat);
      chk("rd_byte_ff", rd, 32'h00000044);
      req(1'b1, 8'h00, 32'h0, 2'b00, rd, er, lat);
      chk("rd_byte_00", rd, 32'h000000A5);

      // reset during WAIT aborts the write
      req(1'b0, 8'h20, 32'h01020304, 2'b10, rd, er, lat);
      @(negedge CLK);
      MFA = 1'b1; RW_RAM = 1'b0; ADDR = 8'h20; DATA_IN = 32'hCAFEF00D; DATA_SIZE = 2'b10;
      @(negedge CLK);
      CLR = 1'b1; MFA = 1'b0;
      @(negedge CLK);
      chk("clr_mfc", {31'd0, MFC}, 32'd0);
      CLR = 1'b0;
      repeat (4) @(negedge CLK);
      chk("clr_mfc_later", {31'd0, MFC}, 32'd0);
      req(1'b1, 8'h20, 32'h0, 2'b10, rd, er, lat);
      chk("rd_after_abort", rd, 32'h01020304);

      // misaligned word read
      req(1'b1, 8'h21, 32'h0, 2'b10, rd, er, lat);
`ifdef RAM_ALIGN_CHECK_EN
      chk("mis_dout", rd, 32'h00000000);
      chk("mis_err", {31'd0, er}, 32'd1);
`else
      chk("mis_dout", rd, 32'h01020304);
      chk("mis_err", {31'd0, er}, 32'd0);
`endif
      chk("mis_latency", 32'(lat), 32'd3);

      // MFA dropped before MFC: request still completes with a single MFC cycle
      @(negedge CLK);
      MFA = 1'b1; RW_RAM = 1'b1; ADDR = 8'h10; DATA_SIZE = 2'b10;
      @(negedge CLK);
      MFA = 1'b0;
      pulses = 0;
      repeat (10) begin
         @(negedge CLK);
         if (MFC) pulses++;
      end
      chk("short_mfa_pulses", 32'(pulses), 32'd1);
      chk("short_mfa_dout", DATA_OUT, 32'hDEADBE55);

      repeat (3) @(negedge CLK);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1);
   end

endmodule
